// File: rtl/bus_region_pkg.sv
// rtl/bus_region_pkg.sv - shared types and default region map for bus_region_ctrl
//
// Purpose: region descriptor struct, FSM state enum and the default
// four-region table of the 8088 system map.
// Ports: none (package).

package bus_region_pkg;

  localparam int CFG_WAIT_W      = 3;
  localparam int DEFAULT_REGIONS = 4;

  typedef struct packed {
    logic [19:0]           base;
    logic [19:0]           mask;
    logic                  iom;
    logic [CFG_WAIT_W-1:0] waits;
  } region_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE,
    ERR
  } state_e;

  function automatic region_cfg_t make_region(
    input logic [19:0]           base,
    input logic [19:0]           mask,
    input logic                  iom,
    input logic [CFG_WAIT_W-1:0] waits
  );
    region_cfg_t r;
    r.base  = base;
    r.mask  = mask;
    r.iom   = iom;
    r.waits = waits;
    return r;
  endfunction

  // Index 0 is the rightmost entry.
  //   0: memory, A19=0
  //   1: memory, A19=1
  //   2: IO, A[15:9]=7'h0E, 2 waits
  //   3: IO, A[15:4]=12'hFF0, 1 wait
  localparam region_cfg_t [DEFAULT_REGIONS-1:0] DEFAULT_CFG = {
    make_region(20'h0FF00, 20'h0FFF0, 1'b1, 3'd1),
    make_region(20'h01C00, 20'h0FE00, 1'b1, 3'd2),
    make_region(20'h80000, 20'h80000, 1'b0, 3'd0),
    make_region(20'h00000, 20'h80000, 1'b0, 3'd0)
  };

endpackage

// File: rtl/bus_region_ctrl_if.sv
// rtl/bus_region_ctrl_if.sv - processor-side bus bundle for bus_region_ctrl
//
// Purpose: groups the 8088 address/strobe inputs and the decode/ready outputs.
// Ports (signals):
//   ALE, IOM, RD, WR, AD[7:0], A[ADDR_W-9:0]   processor -> controller
//   Address, CS, READY, BUS_ERR, ERR_ADDR      controller -> processor/system
// Modports: master (processor side), slave (controller side).

interface bus_region_ctrl_if #(
  parameter int ADDR_W      = 20,
  parameter int NUM_REGIONS = 4
);

  logic                   ALE;
  logic                   IOM;
  logic                   RD;
  logic                   WR;
  logic [7:0]             AD;
  logic [ADDR_W-9:0]      A;
  logic [ADDR_W-1:0]      Address;
  logic [NUM_REGIONS-1:0] CS;
  logic                   READY;
  logic                   BUS_ERR;
  logic [ADDR_W-1:0]      ERR_ADDR;

  modport master (
    output ALE, IOM, RD, WR, AD, A,
    input  Address, CS, READY, BUS_ERR, ERR_ADDR
  );

  modport slave (
    input  ALE, IOM, RD, WR, AD, A,
    output Address, CS, READY, BUS_ERR, ERR_ADDR
  );

endinterface

// File: rtl/ws_counter.sv
// rtl/ws_counter.sv - loadable wait-state down-counter
//
// Purpose: holds the remaining wait clocks of the current access.
// Ports:
//   CLK       in  clock
//   clr       in  synchronous clear to 0 (highest priority)
//   load      in  load load_val
//   load_val  in  W-bit value to load
//   dec       in  decrement by one (saturates at 0)
//   zero      out count is 0

module ws_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bus_region_ctrl.sv
// rtl/bus_region_ctrl.sv - 8088 address latch, region decoder and wait-state FSM
//
// Purpose: latches {A,AD} on ALE, decodes it into one-hot chip selects over
// NUM_REGIONS configurable regions, inserts per-region wait states on READY
// and flags unmapped or double-strobe accesses on BUS_ERR/ERR_ADDR.
// Ports:
//   CLK    in  clock, rising edge
//   RESET  in  synchronous reset, active-high
//   bus    slave side of bus_region_ctrl_if (ALE, IOM, RD, WR, AD, A in;
//          Address, CS, READY, BUS_ERR, ERR_ADDR out)

module bus_region_ctrl
  import bus_region_pkg::*;
#(
  parameter int                             NUM_REGIONS = DEFAULT_REGIONS,
  parameter int                             ADDR_W      = 20,
  parameter int                             WAIT_W      = CFG_WAIT_W,
  parameter region_cfg_t [NUM_REGIONS-1:0]  CFG         = DEFAULT_CFG
) (
  input  logic              CLK,
  input  logic              RESET,
  bus_region_ctrl_if.slave  bus
);

  state_e                 state;
  state_e                 next_state;
  logic [ADDR_W-1:0]      ale_addr;
  logic [NUM_REGIONS-1:0] ale_hit;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W-1:0]      err_addr_q;
  logic [NUM_REGIONS-1:0] cs_q;
  logic [WAIT_W-1:0]      hit_waits;
  logic                   rd_act;
  logic                   wr_act;
  logic                   cnt_clr;
  logic                   cnt_load;
  logic                   cnt_dec;
  logic                   cnt_zero;
  logic                   ready;
  logic                   bus_err;

  assign ale_addr = {bus.A, bus.AD};
  assign rd_act   = ~bus.RD;
  assign wr_act   = ~bus.WR;

  // Decode the incoming address/IOM in the ALE clock and register the result
  // together with the address, so CS is valid in the same clock as Address.
  // The registered decode is the only place the sampled IOM is kept.
  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    ale_hit = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (((ale_addr & ADDR_W'(CFG[i].mask)) ==
           (ADDR_W'(CFG[i].base) & ADDR_W'(CFG[i].mask))) &&
          (bus.IOM == CFG[i].iom)) begin
        ale_hit    = '0;
        ale_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    hit_waits = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (cs_q[i]) begin
        hit_waits = WAIT_W'(CFG[i].waits);
      end
    end
  end

  // Address latch, chip-select and error-address registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q     <= '0;
      cs_q       <= '0;
      err_addr_q <= '0;
    end else if (bus.ALE) begin
      addr_q <= ale_addr;
      cs_q   <= ale_hit;
    end else begin
      if ((next_state == ERR) || (next_state == IDLE)) begin
        cs_q <= '0;
      end
      if ((state == ADDR) && (next_state == ERR)) begin
        err_addr_q <= addr_q;
      end
    end
  end

  // FSM: state register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM: next state. ALE outranks everything and restarts the address phase.
  always_comb begin
    next_state = state;
    if (bus.ALE) begin
      next_state = ADDR;
    end else begin
      case (state)
        IDLE: next_state = IDLE;
        ADDR: begin
          if (rd_act && wr_act) begin
            next_state = ERR;
          end else if (rd_act || wr_act) begin
            if (cs_q == '0) begin
              next_state = ERR;
            end else if (hit_waits == '0) begin
              next_state = DONE;
            end else begin
              next_state = WAIT;
            end
          end
        end
        WAIT: if (cnt_zero) next_state = DONE;
        DONE: if (!rd_act && !wr_act) next_state = IDLE;
        ERR:  next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM: outputs and counter control. The counter is loaded with the full
  // wait count; READY is low while it is non-zero, so the clock in which it
  // reaches 0 already shows READY=1 and the FSM moves on to DONE.
  always_comb begin
    ready    = 1'b1;
    bus_err  = 1'b0;
    cnt_clr  = RESET || bus.ALE;
    cnt_load = (state == ADDR) && (next_state == WAIT);
    cnt_dec  = (state == WAIT) && !cnt_zero;
    if ((state == WAIT) && !cnt_zero) begin
      ready = 1'b0;
    end
    if (state == ERR) begin
      bus_err = 1'b1;
    end
    // An abort releases the processor in the same clock it raises ALE.
    if (bus.ALE) begin
      ready = 1'b1;
    end
  end

  ws_counter #(
    .W (WAIT_W)
  ) u_ws_counter (
    .CLK      (CLK),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (hit_waits),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign bus.Address  = addr_q;
  assign bus.CS       = cs_q;
  assign bus.READY    = ready;
  assign bus.BUS_ERR  = bus_err;
  assign bus.ERR_ADDR = err_addr_q;

endmodule
